// File: rtl/mem_stage_pkg.sv
// Shared widths, opcodes, FSM encoding and request struct for the MEM stage.
package mem_stage_pkg;

  localparam int WIDTH     = 32;
  localparam int IR_W      = WIDTH;
  localparam int PC_W      = WIDTH - 2;
  localparam int NUM_LANES = WIDTH / 8;

  // Opcodes live in IR[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LD    = 6'h20;  // byte load, sign-extended
  localparam logic [5:0] OP_LH    = 6'h21;  // halfword load, sign-extended
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SD    = 6'h28;  // byte store
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_NOP   = 6'h3E;  // matches no WB write case
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [IR_W-1:0] NOP = {OP_NOP, 26'd0};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} msize_e;

  typedef struct packed {
    logic                 we;
    logic [PC_W-1:0]      addr;
    logic [NUM_LANES-1:0] be;
    logic [WIDTH-1:0]     wdata;
  } dmem_req_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Non-memory opcodes report SZ_WORD; callers gate with is_mem().
  function automatic msize_e op_size(input logic [5:0] op);
    case (op)
      OP_LH, OP_SH: return SZ_HALF;
      OP_LD, OP_SD: return SZ_BYTE;
      default:      return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store replication, misalign
// detect (request side) and lane select + sign-extension (load side).
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]           op,
  input  logic [1:0]           off,
  input  logic [WIDTH-1:0]     st_data,
  output logic                 misalign,
  output logic [NUM_LANES-1:0] be,
  output logic [WIDTH-1:0]     wdata,
  input  logic [5:0]           ld_op,
  input  logic [1:0]           ld_off,
  input  logic [WIDTH-1:0]     rdata,
  output logic [WIDTH-1:0]     ld_data
);

  msize_e                      sz, ld_sz;
  logic [NUM_LANES-1:0][7:0]   rd_lanes;
  logic [15:0]                 ld_half;
  logic [7:0]                  ld_byte;

  assign sz       = op_size(op);
  assign ld_sz    = op_size(ld_op);
  assign misalign = (sz == SZ_WORD) ? (|off) : (sz == SZ_HALF) ? off[0] : 1'b0;

  // Per-lane enable and store data: halfword repeats every two lanes,
  // byte repeats in every lane.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] LN = 2'(g);
    localparam int         HB = (g % 2) * 8;
    assign be[g] = (sz == SZ_WORD)
                 | ((sz == SZ_HALF) & (off[1] == LN[1]))
                 | ((sz == SZ_BYTE) & (off == LN));
    assign wdata[g*8 +: 8] = (sz == SZ_WORD) ? st_data[g*8 +: 8] :
                             (sz == SZ_HALF) ? st_data[HB +: 8]  : st_data[7:0];
  end

  assign rd_lanes = rdata;
  assign ld_half  = ld_off[1] ? rdata[31:16] : rdata[15:0];
  assign ld_byte  = rd_lanes[ld_off];

  // Pick the addressed lane(s) and sign-extend to the datapath width.
  always_comb begin
    ld_data = rdata;
    case (ld_sz)
      SZ_HALF: ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      SZ_BYTE: ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data-memory port,
// stalls EX while an access is outstanding, registers results for WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IR_W-1:0]      IR_in,
  input  logic [PC_W-1:0]      PC_in,
  input  logic [WIDTH-1:0]     Z_in,
  input  logic [WIDTH-1:0]     B_in,
  output logic                 stall,
  output logic [IR_W-1:0]      IR_out,
  output logic [PC_W-1:0]      PC_out,
  output logic [WIDTH-1:0]     Z_out,
  output logic                 misalign,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [PC_W-1:0]      dmem_addr,
  output logic [NUM_LANES-1:0] dmem_be,
  output logic [WIDTH-1:0]     dmem_wdata,
  input  logic [WIDTH-1:0]     dmem_rdata,
  input  logic                 dmem_ack
);

  logic [0:0]           state_q, state_d;
  logic [IR_W-1:0]      ir_q, ir_d, ir_out_q, ir_out_d;
  logic [PC_W-1:0]      pc_q, pc_d, pc_out_q, pc_out_d;
  logic [WIDTH-1:0]     z_q, z_d, z_out_q, z_out_d;
  logic                 misalign_q, misalign_d, req_q, req_d;
  dmem_req_t            dreq_q, dreq_d;

  logic                 al_mis;
  logic [NUM_LANES-1:0] al_be;
  logic [WIDTH-1:0]     al_wdata, ld_data;
  logic                 op_mem, mem_go;

  mem_align u_align (
    .op      (IR_in[31:26]),
    .off     (Z_in[1:0]),
    .st_data (B_in),
    .misalign(al_mis),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_op   (ir_q[31:26]),
    .ld_off  (z_q[1:0]),
    .rdata   (dmem_rdata),
    .ld_data (ld_data)
  );

  assign op_mem = is_mem(IR_in[31:26]);
  assign mem_go = (state_q == ST_IDLE) && op_mem && !al_mis;
  // Falls with dmem_ack so EX advances on the completing edge.
  assign stall  = mem_go || ((state_q == ST_WAIT) && !dmem_ack);

  // Next-state: issue, wait for ack, or pass through.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    z_d        = z_q;
    ir_out_d   = ir_out_q;
    pc_out_d   = pc_out_q;
    z_out_d    = z_out_q;
    misalign_d = 1'b0;
    req_d      = req_q;
    dreq_d     = dreq_q;
    if (state_q == ST_IDLE) begin
      if (mem_go) begin
        ir_d     = IR_in;
        pc_d     = PC_in;
        z_d      = Z_in;
        req_d    = 1'b1;
        dreq_d   = '{we: is_store(IR_in[31:26]), addr: Z_in[WIDTH-1:2],
                     be: al_be, wdata: al_wdata};
        ir_out_d = NOP;
        state_d  = ST_WAIT;
      end else if (op_mem) begin
        // Misaligned: no access, WB sees a bubble.
        misalign_d = 1'b1;
        ir_out_d   = NOP;
        pc_out_d   = PC_in;
        z_out_d    = Z_in;
      end else begin
        ir_out_d = IR_in;
        pc_out_d = PC_in;
        z_out_d  = Z_in;
      end
    end else if (dmem_ack) begin
      req_d    = 1'b0;
      ir_out_d = ir_q;
      pc_out_d = pc_q;
      z_out_d  = is_load(ir_q[31:26]) ? ld_data : z_q;
      state_d  = ST_IDLE;
    end
  end

  // State and pipeline-boundary registers; reset abandons any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ir_q       <= NOP;
      pc_q       <= '0;
      z_q        <= '0;
      ir_out_q   <= NOP;
      pc_out_q   <= '0;
      z_out_q    <= '0;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
      dreq_q     <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      z_q        <= z_d;
      ir_out_q   <= ir_out_d;
      pc_out_q   <= pc_out_d;
      z_out_q    <= z_out_d;
      misalign_q <= misalign_d;
      req_q      <= req_d;
      dreq_q     <= dreq_d;
    end
  end

  assign IR_out     = ir_out_q;
  assign PC_out     = pc_out_q;
  assign Z_out      = z_out_q;
  assign misalign   = misalign_q;
  assign dmem_req   = req_q;
  assign dmem_we    = dreq_q.we;
  assign dmem_addr  = dreq_q.addr;
  assign dmem_be    = dreq_q.be;
  assign dmem_wdata = dreq_q.wdata;

endmodule
